wb_stage: RTL

//  Writeback stage: last pipeline stage, drives the write port of the register file (regs).

---
 rtl/core_pkg.sv | 23 ++
 rtl/wb_stage_if.sv | 27 ++
 rtl/wb_load_fmt.sv | 30 +++
 rtl/wb_stage.sv | 112 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared widths, writeback-select and load-type encodings, and the FIFO entry layout.
package core_pkg;
  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int RETIRE_CNT_W = 64;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  // One queued writeback: data is already formatted when it is stored
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB result handshake bundle.
interface wb_stage_if;
  import core_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rd_addr;
  logic                  in_rd_we;
  logic [1:0]            in_wb_sel;
  logic [XLEN-1:0]       in_alu_result;
  logic [XLEN-1:0]       in_pc_plus4;
  logic [XLEN-1:0]       in_load_word;
  logic [2:0]            in_load_funct3;
  logic [1:0]            in_byte_off;

  modport master (
    output in_valid, in_rd_addr, in_rd_we, in_wb_sel, in_alu_result,
           in_pc_plus4, in_load_word, in_load_funct3, in_byte_off,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd_addr, in_rd_we, in_wb_sel, in_alu_result,
           in_pc_plus4, in_load_word, in_load_funct3, in_byte_off,
    output in_ready
  );
endinterface

// File: rtl/wb_load_fmt.sv
// Load formatter: picks the byte/half lane from an aligned word and extends it.
module wb_load_fmt
  import core_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  output logic [XLEN-1:0] data_o
);
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Lane select; the low offset bit is irrelevant for halfwords
  always_comb begin
    byte_s = word_i[8*off_i +: 8];
    half_s = word_i[16*off_i[1] +: 16];
  end

  // Extension by load type; unknown types fall back to a full word
  always_comb begin
    data_o = word_i;
    case (funct3_i)
      LOAD_LB:  data_o = XLEN'(byte_s);
      LOAD_LH:  data_o = XLEN'(half_s);
      LOAD_LBU: data_o = {{(XLEN-8){1'b0}}, byte_s};
      LOAD_LHU: data_o = {{(XLEN-16){1'b0}}, half_s};
      default:  data_o = word_i;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: 2-entry result FIFO feeding the regfile write port,
// with a priority debug write path and a retired-instruction counter.
module wb_stage
  import core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  wb_stage_if.slave               in_if,
  input  logic                    dbg_we,
  input  logic [REG_ADDR_W-1:0]   dbg_addr,
  input  logic [XLEN-1:0]         dbg_data,
  output logic [REG_ADDR_W-1:0]   rd_addr,
  output logic [XLEN-1:0]         rd_data,
  output logic                    write_en,
  output logic                    busy,
  output logic [RETIRE_CNT_W-1:0] retire_count
);
  wb_entry_t             fifo_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [RETIRE_CNT_W-1:0] retire_q, retire_d;

  logic            push, pop;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] src_data;
  wb_entry_t       head;

  wb_load_fmt u_load_fmt (
    .word_i   (in_if.in_load_word),
    .funct3_i (in_if.in_load_funct3),
    .off_i    (in_if.in_byte_off),
    .data_o   (load_data)
  );

  // Ready only reflects occupancy so the sender never sees a pop-dependent path
  assign in_if.in_ready = (count_q != 2'd2);
  assign push = in_if.in_valid && in_if.in_ready;
  assign pop  = (count_q != 2'd0) && !dbg_we;
  assign head = fifo_q[rd_ptr_q];

  // Writeback source select; encoding 11 behaves as ALU
  always_comb begin
    src_data = in_if.in_alu_result;
    case (in_if.in_wb_sel)
      WB_SEL_LOAD: src_data = load_data;
      WB_SEL_PC4:  src_data = in_if.in_pc_plus4;
      default:     src_data = in_if.in_alu_result;
    endcase
  end

  // Pointer, occupancy and retire-count next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    retire_d = retire_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      retire_d = retire_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards anything queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      retire_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      retire_q <= retire_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q].rd   <= in_if.in_rd_addr;
      fifo_q[wr_ptr_q].we   <= in_if.in_rd_we;
      fifo_q[wr_ptr_q].data <= src_data;
    end
  end

  // Regfile port mux: debug wins, then the FIFO head, else idle zeros
  always_comb begin
    rd_addr  = '0;
    rd_data  = '0;
    write_en = 1'b0;
    if (dbg_we) begin
      rd_addr  = dbg_addr;
      rd_data  = dbg_data;
      write_en = (dbg_addr != '0);
    end else if (count_q != 2'd0) begin
      rd_addr  = head.rd;
      rd_data  = head.data;
      write_en = head.we && (head.rd != '0);
    end
  end

  assign busy         = (count_q != 2'd0);
  assign retire_count = retire_q;
endmodule
